id_exe_pipe_reg: RTL and testbench

- Decoupled pipeline register between the ID stage and the EXE stage. Its output feeds the EXE operand logic: Val2 generation, ALU and status update.
- Carries one decoded-instruction packet per transfer under a valid/ready handshake.
- 2-entry skid buffer keeps `in_ready` fully registered, so there is no combinational ready path from EXE back into ID.
- Supports branch flush and hazard freeze.

---
 rtl/arm_pipe_pkg.sv | 37 +++
 rtl/id_exe_pipe_reg_skid.sv | 77 +++++++
 rtl/id_exe_pipe_reg.sv | 103 ++++++++++
 tb/tb_id_exe_pipe_reg.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared ID/EXE packet layout and EXE command encodings.
// Used by the ID/EXE pipeline register and its neighbouring stages.
package arm_pipe_pkg;

    localparam int ID_EXE_PKT_W = 126;

    // Field offsets (LSB of each field) inside the ID/EXE packet
    localparam int OFF_STATUS   = 0;
    localparam int OFF_DEST     = 4;
    localparam int OFF_B        = 8;
    localparam int OFF_S        = 9;
    localparam int OFF_WB_EN    = 10;
    localparam int OFF_MEM_W_EN = 11;
    localparam int OFF_MEM_R_EN = 12;
    localparam int OFF_EXE_CMD  = 13;
    localparam int OFF_IMM      = 17;
    localparam int OFF_SHIFT_OP = 18;
    localparam int OFF_VAL_RM   = 30;
    localparam int OFF_VAL_RN   = 62;
    localparam int OFF_PC       = 94;

    // EXE command encodings (CMP/SUB, TST/AND and LDR/STR/ADD share codes)
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b0100;
    localparam logic [3:0] EXE_TST = 4'b0110;
    localparam logic [3:0] EXE_LDR = 4'b0010;
    localparam logic [3:0] EXE_STR = 4'b0010;

endpackage

// File: rtl/id_exe_pipe_reg_skid.sv
// skid_buffer2: generic 2-entry in-order buffer with flush.
// Exposes next-state occupancy so the owner can register its ready.
module skid_buffer2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   occ_d_o
);

    logic [1:0]   occ_q, occ_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         take;

    // Occupancy/data next state; skid refills main on a take when full
    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        take   = (occ_q != 2'd0) && pop_i;
        case (occ_q)
            2'd0: begin
                if (push_i) begin
                    occ_d  = 2'd1;
                    main_d = data_i;
                end
            end
            2'd1: begin
                if (take && push_i) begin
                    main_d = data_i;
                end else if (take) begin
                    occ_d = 2'd0;
                end else if (push_i) begin
                    occ_d  = 2'd2;
                    skid_d = data_i;
                end
            end
            2'd2: begin
                if (take) begin
                    occ_d  = 2'd1;
                    main_d = skid_q;
                end
            end
            default: occ_d = 2'd0;
        endcase
        if (flush_i) begin
            occ_d  = 2'd0;
            main_d = main_q;
            skid_d = skid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= 2'd0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign valid_o = (occ_q != 2'd0);
    assign data_o  = main_q;
    assign occ_d_o = occ_d;

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE decoupled pipeline register: skid buffer, freeze, flush, bubbles.
// Optional stall/flush counters under `ID_EXE_STALL_STATS_EN.
import arm_pipe_pkg::*;

module id_exe_pipe_reg #(
    parameter int PKT_W           = ID_EXE_PKT_W,
    parameter bit CLEAR_ON_BUBBLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_pkt,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ID_EXE_STALL_STATS_EN
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt,
`endif
    output logic [PKT_W-1:0] out_pkt
);

    logic             in_ready_q, in_ready_d;
    logic             acc;
    logic             buf_valid;
    logic [PKT_W-1:0] buf_data;
    logic [1:0]       occ_d;

    assign acc = in_valid && in_ready_q;

    skid_buffer2 #(
        .W (PKT_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (acc),
        .data_i  (in_pkt),
        .pop_i   (out_ready),
        .valid_o (buf_valid),
        .data_o  (buf_data),
        .occ_d_o (occ_d)
    );

    // Ready looks at next occupancy and the freeze sampled this edge
    always_comb begin
        in_ready_d = (occ_d != 2'd2) && !freeze;
    end

    // Registered ready: no combinational path from EXE back into ID
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    // Bubbles are zeroed so EXE sees no write/memory enables
    always_comb begin
        out_pkt = buf_data;
        if (CLEAR_ON_BUBBLE && !buf_valid) begin
            out_pkt = '0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = buf_valid;

`ifdef ID_EXE_STALL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Count stalled ID cycles and flushes that actually killed something
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (in_valid && !in_ready_q) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (buf_valid || acc)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Bench for id_exe_pipe_reg: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_id_exe_pipe_reg;

    localparam int W = 126;

    logic         clk = 1'b0;
    logic         rst, flush, freeze, in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [W-1:0] in_pkt, out_pkt;
`ifdef ID_EXE_STALL_STATS_EN
    logic [31:0]  stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0] q[$];
    logic         rdy_m;
    int unsigned  stall_m;
    int unsigned  flush_m;

    always #5 clk = ~clk;

    id_exe_pipe_reg #(
        .PKT_W           (W),
        .CLEAR_ON_BUBBLE (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .freeze    (freeze),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pkt    (in_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ID_EXE_STALL_STATS_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .out_pkt   (out_pkt)
    );

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mkpkt(input logic [31:0] pc);
        logic [W-1:0] p;
        p = {$urandom, $urandom, $urandom, $urandom};
        p[125:94] = pc;
        return p;
    endfunction

    // model update at the active edge, using inputs held stable
    task automatic model_edge();
        logic a, t;
        if (rst) begin
            q.delete();
            rdy_m   = 1'b1;
            stall_m = 0;
            flush_m = 0;
        end else begin
            a = in_valid && rdy_m;
            t = (q.size() > 0) && out_ready;
            if (in_valid && !rdy_m) stall_m++;
            if (flush && (q.size() > 0 || a)) flush_m++;
            if (t) void'(q.pop_front());
            if (a) q.push_back(in_pkt);
            if (flush) q.delete();
            rdy_m = (q.size() < 2) && !freeze;
        end
    endtask

    task automatic compare();
        logic [W-1:0] e;
        e = (q.size() > 0) ? q[0] : '0;
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("in_ready", 128'(in_ready), 128'(rdy_m));
        chk("out_pkt", 128'(out_pkt), 128'(e));
`ifdef ID_EXE_STALL_STATS_EN
        chk("stall_cnt", 128'(stall_cnt), 128'(stall_m));
        chk("flush_cnt", 128'(flush_cnt), 128'(flush_m));
`endif
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] p,
                       input logic ordy, input logic fl,
                       input logic fz, input logic r);
        in_valid  = v;
        in_pkt    = p;
        out_ready = ordy;
        flush     = fl;
        freeze    = fz;
        rst       = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    function automatic logic [127:0] pc_of(input logic [W-1:0] p);
        return 128'(p[125:94]);
    endfunction

    initial begin
        rdy_m = 1'b1;
        stall_m = 0;
        flush_m = 0;
        @(negedge clk);

        // reset state
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(1));
        chk("rst_pkt", 128'(out_pkt), 128'(0));

        // streaming with out_ready held
        cyc(1'b1, mkpkt(32'h0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s0_pc", pc_of(out_pkt), 128'(32'h0));
        chk("s0_v", 128'(out_valid), 128'(1));
        cyc(1'b1, mkpkt(32'h4), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s1_pc", pc_of(out_pkt), 128'(32'h4));
        cyc(1'b1, mkpkt(32'h8), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s2_pc", pc_of(out_pkt), 128'(32'h8));
        chk("s2_rdy", 128'(in_ready), 128'(1));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s_empty", 128'(out_valid), 128'(0));

        // backpressure fills both entries
        cyc(1'b1, mkpkt(32'h10), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, mkpkt(32'h14), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_rdy", 128'(in_ready), 128'(0));
        chk("bp_pc", pc_of(out_pkt), 128'(32'h10));
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_hold", pc_of(out_pkt), 128'(32'h10));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_pc2", pc_of(out_pkt), 128'(32'h14));
        chk("bp_rdy2", 128'(in_ready), 128'(1));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // flush while full
        cyc(1'b1, mkpkt(32'h40), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, mkpkt(32'h44), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, mkpkt(32'h20), 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fl_valid", 128'(out_valid), 128'(0));
        chk("fl_pkt", 128'(out_pkt), 128'(0));
        chk("fl_rdy", 128'(in_ready), 128'(1));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fl_no20", 128'(out_valid), 128'(0));

        // freeze for three cycles with 0x30 presented
        cyc(1'b1, mkpkt(32'h30), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fz_rdy0", 128'(in_ready), 128'(0));
        chk("fz_pc", pc_of(out_pkt), 128'(32'h30));
        cyc(1'b1, mkpkt(32'h30), 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, mkpkt(32'h30), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fz_rdy2", 128'(in_ready), 128'(0));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fz_nodup", 128'(out_valid), 128'(0));
        chk("fz_rel", 128'(in_ready), 128'(1));

        // reset wins over flush/freeze while full
        cyc(1'b1, mkpkt(32'h50), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, mkpkt(32'h54), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, mkpkt(32'h58), 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rm_valid", 128'(out_valid), 128'(0));
        chk("rm_ready", 128'(in_ready), 128'(1));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0),
                mkpkt($urandom),
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 6) == 0),
                1'($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
